// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared types for the cache memory-port arbiter.
//   state_t - arbiter FSM encoding (ST_IDLE / ST_BUSY / ST_GAP)
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i   - request vector
//   ptr_i   - highest-priority index this round (must be < NUM_REQ)
//   grant_o - one-hot winner (0 when nothing requests)
//   idx_o   - binary winner index
//   any_o   - at least one request present
module rr_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       any_o
);

    localparam int PW = $clog2(NUM_REQ);

    // Walk priorities lowest-first so the closest index to ptr_i
    // (offset 0) is the last writer and wins. The wrap is an explicit
    // subtract so non-power-of-two NUM_REQ works.
    always_comb begin
        int cand;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_i[i] && (i == cand)) begin
                    grant_o    = '0;
                    grant_o[i] = 1'b1;
                    idx_o      = PW'(i);
                    any_o      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one valid/ready memory port between NUM_REQ
// cache memory-side masters, round-robin.
//   clk_i, rst_i              - clock, async active-high reset
//   req_valid_i/we/adr/wdata  - per-requester command (flattened buses)
//   req_ready_o, req_err_o    - per-requester completion / abort strobes
//   req_rdata_o               - shared read data, qualified by req_ready_o
//   mem_*                     - single downstream memory port
//   grant_o, busy_o           - current one-hot grant, FSM not idle
// Optional: define CACHE_MEM_ARBITER_TIMEOUT_EN to abort a transaction
// after TIMEOUT_CYCLES busy cycles without mem_ready_i.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_adr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic [DATA_WIDTH-1:0]         req_rdata_o,
    output logic [NUM_REQ-1:0]            req_err_o,
    output logic                          mem_valid_o,
    input  logic                          mem_ready_i,
    output logic                          mem_we_o,
    output logic [ADDR_WIDTH-1:0]         mem_adr_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    state_t                 state_q, state_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]          win_q, win_d;
    logic                   mem_valid_q, mem_valid_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_adr_q, mem_adr_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;

    logic [NUM_REQ-1:0]     arb_grant;
    logic [PW-1:0]          arb_idx;
    logic                   arb_any;
    logic                   sel_we;
    logic [ADDR_WIDTH-1:0]  sel_adr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic                   tmo_hit;
    logic                   done;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // One-hot AND-OR mux of the winner's command.
    always_comb begin
        sel_we    = 1'b0;
        sel_adr   = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_we    = req_we_i[i];
                sel_adr   = req_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef CACHE_MEM_ARBITER_TIMEOUT_EN
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = (state_q == ST_BUSY) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Counts busy cycles without ready; never runs past the limit
    // because the limit cycle always ends the transaction.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_IDLE && arb_any)
            tmo_cnt_d = '0;
        else if (state_q == ST_BUSY && !mem_ready_i && !tmo_hit)
            tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) tmo_cnt_q <= '0;
        else       tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic [TW-1:0] tmo_unused;
    assign tmo_unused = TW'(TIMEOUT_CYCLES - 1);
    assign tmo_hit    = 1'b0;
`endif

    // A ready in the limit cycle wins over the abort.
    assign done        = (state_q == ST_BUSY) && (mem_ready_i || tmo_hit);
    assign req_ready_o = done ? grant_q : '0;
    assign req_err_o   = (tmo_hit && !mem_ready_i) ? grant_q : '0;
    assign req_rdata_o = mem_rdata_i;
    assign busy_o      = (state_q != ST_IDLE);

    assign mem_valid_o = mem_valid_q;
    assign mem_we_o    = mem_we_q;
    assign mem_adr_o   = mem_adr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign grant_o     = grant_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        grant_d     = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    mem_valid_d = 1'b1;
                    mem_we_d    = sel_we;
                    mem_adr_d   = sel_adr;
                    mem_wdata_d = sel_wdata;
                    grant_d     = arb_grant;
                    win_d       = arb_idx;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (done) begin
                    mem_valid_d = 1'b0;
                    grant_d     = '0;
                    rr_ptr_d    = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                    state_d     = ST_GAP;
                end
            end
            // One idle cycle lets the finished requester drop its valid.
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            grant_q     <= grant_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: scoreboard bench for cache_mem_arbiter
// (NUM_REQ=2, ADDR_WIDTH=16, DATA_WIDTH=32, TIMEOUT_CYCLES=8).
module tb_cache_mem_arbiter;

    localparam int NR = 2;
    localparam int AW = 16;
    localparam int DW = 32;

    logic              clk_i;
    logic              rst_i;
    logic [NR-1:0]     req_valid_i;
    logic [NR-1:0]     req_ready_o;
    logic [NR-1:0]     req_we_i;
    logic [NR*AW-1:0]  req_adr_i;
    logic [NR*DW-1:0]  req_wdata_i;
    logic [DW-1:0]     req_rdata_o;
    logic [NR-1:0]     req_err_o;
    logic              mem_valid_o;
    logic              mem_ready_i;
    logic              mem_we_o;
    logic [AW-1:0]     mem_adr_o;
    logic [DW-1:0]     mem_wdata_o;
    logic [DW-1:0]     mem_rdata_i;
    logic [NR-1:0]     grant_o;
    logic              busy_o;

    cache_mem_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_adr_i(req_adr_i), .req_wdata_i(req_wdata_i),
        .req_rdata_o(req_rdata_o), .req_err_o(req_err_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .grant_o(grant_o), .busy_o(busy_o)
    );

    typedef struct {
        int          req;
        logic        we;
        logic [15:0] adr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic auto_mem = 1'b0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] rd_fn(input logic [15:0] a);
        return {~a, a};
    endfunction

    task automatic set_req(input int i, input logic we, input logic [15:0] a, input logic [31:0] wd);
        req_we_i[i] = we;
        req_adr_i[i*AW +: AW] = a;
        req_wdata_i[i*DW +: DW] = wd;
    endtask

    task automatic push_exp(input int r, input logic we, input logic [15:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input logic err);
        exp_t e;
        e.req = r; e.we = we; e.adr = a; e.wdata = wd; e.rdata = rd; e.err = err;
        sb.push_back(e);
    endtask

    // Zero-wait memory responder: ready follows valid for one cycle.
    initial forever begin
        @(posedge clk_i);
        #1;
        if (auto_mem) begin
            mem_ready_i = mem_valid_o;
            mem_rdata_i = rd_fn(mem_adr_o);
        end
    end

    // Completion monitor: every req_ready_o pulse consumes one expectation.
    initial forever begin
        @(negedge clk_i);
        if (req_err_o != '0 && req_ready_o == '0)
            chk("err_without_ready", 64'(req_err_o), 64'(0));
        if (req_ready_o != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 64'(req_ready_o), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                chk("ready_vec", 64'(req_ready_o), 64'(NR'(1) << mon_e.req));
                chk("err_vec", 64'(req_err_o), mon_e.err ? 64'(NR'(1) << mon_e.req) : 64'(0));
                chk("cmp_valid", 64'(mem_valid_o), 64'(1));
                chk("cmp_we", 64'(mem_we_o), 64'(mon_e.we));
                chk("cmp_adr", 64'(mem_adr_o), 64'(mon_e.adr));
                if (mon_e.we)
                    chk("cmp_wdata", 64'(mem_wdata_o), 64'(mon_e.wdata));
                else if (!mon_e.err)
                    chk("cmp_rdata", 64'(req_rdata_o), 64'(mon_e.rdata));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        req_valid_i = '0; req_we_i = '0; req_adr_i = '0; req_wdata_i = '0;
        mem_ready_i = 1'b0; mem_rdata_i = '0;

        // reset state
        tick;
        chk("rst_mem_valid", 64'(mem_valid_o), 64'(0));
        chk("rst_mem_we", 64'(mem_we_o), 64'(0));
        chk("rst_mem_adr", 64'(mem_adr_o), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata_o), 64'(0));
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_ready", 64'(req_ready_o), 64'(0));
        chk("rst_err", 64'(req_err_o), 64'(0));
        tick;
        rst_i = 1'b0;
        tick;

        // single write, ready in cycle 3
        set_req(0, 1'b1, 16'h1234, 32'hDEADBEEF);
        req_valid_i = 2'b01;
        push_exp(0, 1'b1, 16'h1234, 32'hDEADBEEF, 32'h0, 1'b0);
        tick;
        chk("t1_valid", 64'(mem_valid_o), 64'(1));
        chk("t1_adr", 64'(mem_adr_o), 64'h1234);
        chk("t1_we", 64'(mem_we_o), 64'(1));
        chk("t1_wdata", 64'(mem_wdata_o), 64'hDEADBEEF);
        chk("t1_grant", 64'(grant_o), 64'(2'b01));
        chk("t1_busy", 64'(busy_o), 64'(1));
        tick; tick;
        chk("t1_hold", 64'(mem_valid_o), 64'(1));
        mem_ready_i = 1'b1;
        tick;
        mem_ready_i = 1'b0; req_valid_i = '0;
        chk("t1_valid_drop", 64'(mem_valid_o), 64'(0));
        chk("t1_gap_grant", 64'(grant_o), 64'(0));
        chk("t1_gap_busy", 64'(busy_o), 64'(1));
        tick;
        chk("t1_idle", 64'(busy_o), 64'(0));

        // read by requester 1
        set_req(1, 1'b0, 16'h0040, 32'h0);
        req_valid_i = 2'b10;
        push_exp(1, 1'b0, 16'h0040, 32'h0, 32'hCAFEF00D, 1'b0);
        tick;
        chk("t2_grant", 64'(grant_o), 64'(2'b10));
        chk("t2_we", 64'(mem_we_o), 64'(0));
        req_valid_i = '0;
        mem_rdata_i = 32'hCAFEF00D; mem_ready_i = 1'b1;
        tick;
        mem_ready_i = 1'b0;
        tick;

        // requester drops valid while busy
        set_req(0, 1'b1, 16'h0BEE, 32'h12345678);
        req_valid_i = 2'b01;
        push_exp(0, 1'b1, 16'h0BEE, 32'h12345678, 32'h0, 1'b0);
        tick;
        req_valid_i = '0;
        chk("t4_grant", 64'(grant_o), 64'(2'b01));
        repeat (3) begin
            tick;
            chk("t4_hold_valid", 64'(mem_valid_o), 64'(1));
            chk("t4_hold_adr", 64'(mem_adr_o), 64'h0BEE);
        end
        mem_ready_i = 1'b1;
        tick;
        mem_ready_i = 1'b0;
        chk("t4_done", 64'(mem_valid_o), 64'(0));
        tick;

        // contention after reset, zero-wait memory
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        set_req(0, 1'b0, 16'h0100, 32'h0);
        set_req(1, 1'b0, 16'h0200, 32'h0);
        req_valid_i = 2'b11;
        auto_mem = 1'b1;
        for (int t = 0; t < 4; t++)
            push_exp(t % 2, 1'b0, (t % 2 == 0) ? 16'h0100 : 16'h0200, 32'h0,
                     rd_fn((t % 2 == 0) ? 16'h0100 : 16'h0200), 1'b0);
        for (int c = 0; c < 12; c++) begin
            tick;
            chk("t3_grant", 64'(grant_o),
                (c % 3 == 0) ? 64'(NR'(1) << ((c / 3) % 2)) : 64'(0));
        end
        req_valid_i = '0;
        auto_mem = 1'b0;
        tick;

        // move rr pointer to 1 so the reset test can see it return to 0
        set_req(0, 1'b0, 16'h0077, 32'h0);
        req_valid_i = 2'b01;
        push_exp(0, 1'b0, 16'h0077, 32'h0, 32'h77777777, 1'b0);
        tick;
        req_valid_i = '0;
        mem_rdata_i = 32'h77777777; mem_ready_i = 1'b1;
        tick;
        mem_ready_i = 1'b0;
        tick;

        // reset mid-transaction
        set_req(1, 1'b1, 16'h0555, 32'h55555555);
        req_valid_i = 2'b10;
        tick;
        chk("t5_grant_pre", 64'(grant_o), 64'(2'b10));
        req_valid_i = '0;
        #2 rst_i = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(mem_valid_o), 64'(0));
        chk("t5_rst_grant", 64'(grant_o), 64'(0));
        chk("t5_rst_busy", 64'(busy_o), 64'(0));
        tick;
        rst_i = 1'b0;
        set_req(0, 1'b1, 16'h0AAA, 32'hAAAA0000);
        req_valid_i = 2'b11;
        push_exp(0, 1'b1, 16'h0AAA, 32'hAAAA0000, 32'h0, 1'b0);
        tick;
        chk("t5_grant_post", 64'(grant_o), 64'(2'b01));
        req_valid_i = '0;
        mem_ready_i = 1'b1;
        tick;
        mem_ready_i = 1'b0;
        tick;

`ifdef CACHE_MEM_ARBITER_TIMEOUT_EN
        // timeout abort after 8 busy cycles
        set_req(0, 1'b1, 16'h0DEA, 32'h0BADC0DE);
        req_valid_i = 2'b01;
        push_exp(0, 1'b1, 16'h0DEA, 32'h0BADC0DE, 32'h0, 1'b1);
        tick;
        req_valid_i = '0;
        chk("t6_busy", 64'(busy_o), 64'(1));
        repeat (7) tick;
        chk("t6_still_valid", 64'(mem_valid_o), 64'(1));
        tick;
        chk("t6_valid_drop", 64'(mem_valid_o), 64'(0));
        mem_ready_i = 1'b1;
        #2;
        chk("t6_late_ready", 64'(req_ready_o), 64'(0));
        chk("t6_late_err", 64'(req_err_o), 64'(0));
        tick;
        mem_ready_i = 1'b0;
        tick;
`endif

        tick;
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
